// File: rtl/dot_product_pkg.sv
// Shared constants and FSM state type for the dot-product controller.
// Contents: ELEM_W (element width), N_ELEM (elements per vector), ACC_W (accumulator width),
// derived widths, and the controller state enum.
package dot_product_pkg;

    localparam int unsigned ELEM_W = 8;
    localparam int unsigned N_ELEM = 4;
    localparam int unsigned ACC_W  = 18;
    localparam int unsigned PROD_W = 2 * ELEM_W;
    localparam int unsigned IDX_W  = $clog2(N_ELEM);
    localparam int unsigned VEC_W  = ELEM_W * N_ELEM;

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StDrain,
        StDone
    } state_t;

endpackage

// File: rtl/dot_product_ctrl_mac_unit.sv
// mac_unit: 8x8 multiply feeding an 18-bit accumulator.
// The operands arrive from registers in the controller, so the product path starts at a flop.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - clear accumulator (priority over en)
//   en        - add a*b into the accumulator on this edge
//   a, b      - ELEM_W-bit operands
//   acc_sum   - accumulator plus current product (the value the next enabled edge stores)
// Macro DOT_PRODUCT_SIGNED_EN: when defined operands are two's complement, else unsigned.
module mac_unit
    import dot_product_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    output logic [ACC_W-1:0]  acc_sum
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] prod_ext;

`ifdef DOT_PRODUCT_SIGNED_EN
    logic signed [PROD_W-1:0] prod;
    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
`else
    logic [PROD_W-1:0] prod;
    assign prod     = a * b;
    assign prod_ext = {{(ACC_W-PROD_W){1'b0}}, prod};
`endif

    // Same adder in both modes: two's complement makes the signed sum bit-identical.
    assign acc_sum = acc + prod_ext;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_sum;
        end
    end

endmodule

// File: rtl/dot_product_ctrl.sv
// dot_product_ctrl: accepts a pair of 4x8-bit packed vectors, feeds element pairs to a MAC one
// per cycle and returns the 18-bit dot product, held until acknowledged.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid / in_ready   - input handshake for A_entire/B_entire
//   A_entire, B_entire    - packed input vectors
//   elem_A, elem_B        - element pair presented to the MAC (held when mac_enable=0)
//   mac_enable            - elem_A/elem_B are being accumulated
//   result / result_valid - dot product, valid until result_ack
//   result_ack            - consumer accepts result (only honoured while done)
//   busy                  - controller not idle
// Parameter MSB_FIRST: 1 feeds byte [31:24] first, 0 feeds byte [7:0] first.
// Macro DOT_PRODUCT_SIGNED_EN selects signed elements (see mac_unit).
module dot_product_ctrl
    import dot_product_pkg::*;
#(
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VEC_W-1:0]  A_entire,
    input  logic [VEC_W-1:0]  B_entire,
    output logic [ELEM_W-1:0] elem_A,
    output logic [ELEM_W-1:0] elem_B,
    output logic              mac_enable,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    input  logic              result_ack,
    output logic              busy
);

    state_t            state;
    logic [VEC_W-1:0]  a_q;
    logic [VEC_W-1:0]  b_q;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  sel;
    logic              accept;
    logic [ACC_W-1:0]  acc_sum;

    assign in_ready = (state == StIdle);
    assign busy     = (state != StIdle);
    assign accept   = in_valid && in_ready;

    // Map feed order onto byte position within the captured word.
    assign sel = (MSB_FIRST != 0) ? (IDX_W'(N_ELEM - 1) - idx) : idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            a_q          <= '0;
            b_q          <= '0;
            idx          <= '0;
            elem_A       <= '0;
            elem_B       <= '0;
            mac_enable   <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        a_q   <= A_entire;
                        b_q   <= B_entire;
                        idx   <= '0;
                        state <= StFeed;
                    end
                end
                StFeed: begin
                    elem_A     <= a_q[sel*ELEM_W +: ELEM_W];
                    elem_B     <= b_q[sel*ELEM_W +: ELEM_W];
                    mac_enable <= 1'b1;
                    idx        <= idx + IDX_W'(1);
                    if (idx == IDX_W'(N_ELEM - 1)) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    // Last product is still in flight; take the sum the MAC stores this edge.
                    mac_enable   <= 1'b0;
                    result       <= acc_sum;
                    result_valid <= 1'b1;
                    state        <= StDone;
                end
                StDone: begin
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        state        <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    mac_unit u_mac (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (mac_enable),
        .a       (elem_A),
        .b       (elem_B),
        .acc_sum (acc_sum)
    );

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Directed bench for dot_product_ctrl: one instance per element order, shared inputs.
module tb_dot_product_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        result_ack;
    logic [31:0] A_entire;
    logic [31:0] B_entire;

    logic        in_ready_m, in_ready_l;
    logic [7:0]  elem_A_m, elem_B_m, elem_A_l, elem_B_l;
    logic        mac_en_m, mac_en_l;
    logic [17:0] result_m, result_l;
    logic        rv_m, rv_l;
    logic        busy_m, busy_l;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dot_product_ctrl #(.MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
        .A_entire(A_entire), .B_entire(B_entire), .elem_A(elem_A_m), .elem_B(elem_B_m),
        .mac_enable(mac_en_m), .result(result_m), .result_valid(rv_m),
        .result_ack(result_ack), .busy(busy_m)
    );

    dot_product_ctrl #(.MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
        .A_entire(A_entire), .B_entire(B_entire), .elem_A(elem_A_l), .elem_B(elem_B_l),
        .mac_enable(mac_en_l), .result(result_l), .result_valid(rv_l),
        .result_ack(result_ack), .busy(busy_l)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Handshake at T0, feed T1..T4, result at T5; leaves the DUTs in DONE.
    task automatic run_to_result(input string tag, input logic [31:0] a, input logic [31:0] b,
                                 input logic [17:0] exp, input bit scramble);
        logic [31:0] seq_m, seq_l, exp_l;
        A_entire = a;
        B_entire = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy_m}, 32'd1);
        chk({tag, "_in_ready_low"}, {31'd0, in_ready_m}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (scramble) begin
                A_entire = $urandom;
                B_entire = $urandom;
            end
            step();
            seq_m[31-8*i -: 8] = elem_A_m;
            seq_l[31-8*i -: 8] = elem_A_l;
            chk({tag, "_mac_en"}, {31'd0, mac_en_m}, 32'd1);
        end
        chk({tag, "_rv_early"}, {31'd0, rv_m}, 32'd0);
        step();
        for (int k = 0; k < 4; k++) exp_l[31-8*k -: 8] = a[8*k +: 8];
        chk({tag, "_rv"}, {31'd0, rv_m}, 32'd1);
        chk({tag, "_result_msb"}, {14'd0, result_m}, {14'd0, exp});
        chk({tag, "_result_lsb"}, {14'd0, result_l}, {14'd0, exp});
        chk({tag, "_seq_msb"}, seq_m, a);
        chk({tag, "_seq_lsb"}, seq_l, exp_l);
        chk({tag, "_mac_off"}, {31'd0, mac_en_m}, 32'd0);
        chk({tag, "_elem_hold"}, {24'd0, elem_A_m}, {24'd0, a[7:0]});
    endtask

    task automatic ack(input string tag, input logic [17:0] exp);
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        chk({tag, "_rv_clr"}, {31'd0, rv_m}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready_m}, 32'd1);
        chk({tag, "_result_kept"}, {14'd0, result_m}, {14'd0, exp});
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        result_ack = 1'b0;
        A_entire   = 32'h0;
        B_entire   = 32'h0;
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready_m}, 32'd1);
        chk("rst_busy", {31'd0, busy_m}, 32'd0);
        chk("rst_result", {14'd0, result_m}, 32'd0);
        chk("rst_rv", {31'd0, rv_m}, 32'd0);
        chk("rst_mac_en", {31'd0, mac_en_m}, 32'd0);
        chk("rst_elem", {elem_A_m, elem_B_m, elem_A_l, elem_B_l}, 32'd0);

        // Basic vector: 1*5 + 2*6 + 3*7 + 4*8 = 70
        run_to_result("basic", 32'h01020304, 32'h05060708, 18'd70, 1'b0);
        ack("basic", 18'd70);
        // result_ack outside DONE is ignored
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        chk("idle_ack_ignored", {31'd0, in_ready_m}, 32'd1);

`ifdef DOT_PRODUCT_SIGNED_EN
        run_to_result("all_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 18'd4, 1'b0);
        ack("all_ff", 18'd4);
        run_to_result("neg_one", 32'hFFFFFFFF, 32'h01010101, 18'h3FFFC, 1'b0);
        ack("neg_one", 18'h3FFFC);
        // 127*127 - 128*127 - 1*2 + 1*3 = -126
        run_to_result("mixed", 32'h7F80FF01, 32'h7F7F0203, 18'h3FF82, 1'b0);
        ack("mixed", 18'h3FF82);
`else
        run_to_result("all_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 18'h3F804, 1'b0);
        ack("all_ff", 18'h3F804);
        run_to_result("neg_one", 32'hFFFFFFFF, 32'h01010101, 18'd1020, 1'b0);
        ack("neg_one", 18'd1020);
        // 16129 + 16256 + 510 + 3 = 32898
        run_to_result("mixed", 32'h7F80FF01, 32'h7F7F0203, 18'h08082, 1'b0);
        ack("mixed", 18'h08082);
`endif
        // (-128)^2 * 4 and 128^2 * 4 are both 65536
        run_to_result("min_neg", 32'h80808080, 32'h80808080, 18'h10000, 1'b0);
        ack("min_neg", 18'h10000);

        // Inputs churn after capture: 10*2 + 20*3 + 30*4 + 40*5 = 400
        run_to_result("scramble", 32'h0A141E28, 32'h02030405, 18'd400, 1'b1);
        ack("scramble", 18'd400);

        // Hold result 10 cycles with in_valid high: no capture, outputs stable
        run_to_result("hold", 32'h01010101, 32'h02020202, 18'd8, 1'b0);
        A_entire = 32'h01020304;
        B_entire = 32'h05060708;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_rv", {31'd0, rv_m}, 32'd1);
            chk("hold_result", {14'd0, result_m}, 32'd8);
            chk("hold_in_ready", {31'd0, in_ready_m}, 32'd0);
        end
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        chk("hold_ack_in_ready", {31'd0, in_ready_m}, 32'd1);
        chk("hold_ack_rv", {31'd0, rv_m}, 32'd0);
        // in_valid still high: the pending pair is taken now
        run_to_result("after_hold", 32'h01020304, 32'h05060708, 18'd70, 1'b0);
        ack("after_hold", 18'd70);

        // Reset on the second feed edge
        A_entire = 32'hFFFFFFFF;
        B_entire = 32'hFFFFFFFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_in_ready", {31'd0, in_ready_m}, 32'd1);
        chk("abort_busy", {31'd0, busy_m}, 32'd0);
        chk("abort_outs", {elem_A_m, elem_B_m, 7'd0, mac_en_m, 7'd0, rv_m}, 32'd0);
        chk("abort_result", {14'd0, result_m}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort_no_rv", {31'd0, rv_m}, 32'd0);
        end
        run_to_result("post_abort", 32'h01020304, 32'h05060708, 18'd70, 1'b0);
        ack("post_abort", 18'd70);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dot_product_ctrl.md
DOT_PRODUCT_CTRL -- requirements
Module: dot_product_ctrl

Interface
REQ-001 Parameter MSB_FIRST, default 1, element order: 1 = byte [31:24] fed first, 0 = byte [7:0] fed first.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  vector pair on A_entire/B_entire is valid.
REQ-005 in_ready  output  1  block can accept a vector pair.
REQ-006 A_entire  input  32  four packed 8-bit elements of vector A.
REQ-007 B_entire  input  32  four packed 8-bit elements of vector B.
REQ-008 elem_A  output  8  current A element presented to the MAC.
REQ-009 elem_B  output  8  current B element presented to the MAC.
REQ-010 mac_enable  output  1  elem_A/elem_B valid this cycle; accumulate.
REQ-011 result  output  18  dot product.
REQ-012 result_valid  output  1  result is final.
REQ-013 result_ack  input  1  consumer accepts result.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states are IDLE, FEED, DRAIN and DONE; in_ready = (state == IDLE).
REQ-016 IDLE: on edge T0 with in_valid && in_ready, capture A_entire/B_entire into internal registers, clear accumulator and element index, go to FEED.
REQ-017 FEED: on edges T1..T4, register elem_A/elem_B from captured byte idx, set mac_enable=1, increment idx 0..3; after T4 go to DRAIN.
REQ-018 Accumulator adds elem_A*elem_B on every edge where registered mac_enable=1 (edges T2..T5).
REQ-019 DRAIN: on edge T5, mac_enable<=0, result<=final accumulator, result_valid<=1, go to DONE; latency from handshake to result_valid is exactly 5 cycles.
REQ-020 DONE: result and result_valid held stable until result_ack=1; on that edge result_valid<=0 and state returns to IDLE; result keeps its value.
REQ-021 result_ack outside DONE is ignored; in_valid outside IDLE is ignored, and no capture occurs.
REQ-022 Changes on A_entire/B_entire after capture do not affect the running computation.
REQ-023 Minimum issue interval is 6 cycles (handshake, 4 feed, 1 drain) plus 1 cycle for ack; acceptance of the next pair is no earlier than 1 cycle after the ack edge.
REQ-024 Products are 16 bits and the accumulator is 18 bits; no wrap occurs for any legal input in either signedness mode.
REQ-025 elem_A/elem_B hold their last value when mac_enable=0.

Reset
REQ-026 rst=1 at any edge forces IDLE; elem_A, elem_B, mac_enable, result, result_valid, busy and the accumulator become 0, and in_ready becomes 1 in the following cycle.
REQ-027 Reset mid-operation discards the partial sum; no result_valid pulse is produced for the aborted operation.

Configuration
REQ-028 DOT_PRODUCT_SIGNED_EN defined: elements are two's complement and products/accumulator are signed (range -65024..65536); undefined: elements are unsigned (range 0..260100).

Structure
REQ-029 Package dot_product_pkg holds ELEM_W=8, N_ELEM=4, ACC_W=18 and the FSM state typedef.
REQ-030 Sub-module mac_unit (registered 8x8 multiply, 18-bit accumulate, clear and enable inputs, signedness set by the macro) is instantiated once.

Verification
REQ-031 A=0x01020304, B=0x05060708 -> result=70 (0x00046) with result_valid exactly 5 cycles after the handshake; elem_A sequence 1,2,3,4 when MSB_FIRST=1 and 4,3,2,1 when MSB_FIRST=0.
REQ-032 Unsigned build, A=B=0xFFFFFFFF -> result=260100 (0x3F804); signed build, same input -> result=4.
REQ-033 Signed build, A=B=0x80808080 -> 65536; A=0xFFFFFFFF, B=0x01010101 -> 0x3FFFC (-4).
REQ-034 result_ack held low 10 cycles with in_valid high -> result and result_valid stable, in_ready=0, no capture; ack -> in_ready=1 on the next cycle.
REQ-035 rst on second FEED cycle -> all outputs 0 next cycle with in_ready=1; a following pair A=0x01020304, B=0x05060708 -> result=70.
REQ-036 A_entire/B_entire changed every cycle after the handshake -> result equals the dot product of the captured values.
